hex_rate_sequencer: RTL and testbench
=====================================

Name: hex_rate_sequencer

Overview:
Run/pause/clear controller that sequences the rate-divider and hex-digit datapath that drives one 7-segment display. It selects one of four tick periods and starts, pauses and resumes the divider. It applies speed changes only at tick boundaries, so no period is ever shortened or stretched mid-count. It owns the 4-bit display digit, which counts up or down, and it feeds a seven-segment decoder.

Parameters:
CLK_HZ, 50000000, input clock frequency; one slow period equals CLK_HZ cycles (1 s).
CNT_W, 28, divider width; must hold 4*CLK_HZ-1.

Ports:
CLOCK_50  input  1  system clock.
Reset  input  1  synchronous, active-high reset.
speed_sel  input  2  rate select: 00=every cycle, 01=CLK_HZ, 10=2*CLK_HZ, 11=4*CLK_HZ cycles per tick.
start  input  1  level, sampled each cycle; run or resume.
stop  input  1  level; pause.
clear  input  1  level; return to idle, digit to 0.
up_down  input  1  1 = increment, 0 = decrement; sampled at each tick.
digit  output  4  current hex value.
tick  output  1  one-cycle pulse on the cycle the digit updates (registered).
running  output  1  high in RUN state.
HEX0  output  7  active-low segment drive for digit; combinational from digit.

Behaviour:
- One clock (CLOCK_50); reset is synchronous and active-high.
- Reset values: state=IDLE, digit=0, tick=0, running=0, divider=0, active_sel=00.
- States are IDLE, RUN and PAUSE.
- Control priority within a cycle: clear > stop > start.
- IDLE:
  - start=1 -> RUN; latch active_sel=speed_sel; load divider = period(speed_sel)-1.
  - stop alone has no effect.
- RUN:
  - Divider decrements by 1 per cycle.
  - When divider==0 and no clear/stop: assert tick next cycle; digit = digit±1 mod 16 (F+1->0, 0-1->F); re-latch active_sel=speed_sel; reload divider = period(new sel)-1.
  - stop=1 -> PAUSE; divider frozen; no tick that cycle, even if divider==0.
- PAUSE:
  - Divider and digit held.
  - start=1 -> RUN; counting resumes from the held divider value with no reload.
  - A speed_sel change made while paused takes effect at the next tick reload.
- clear=1 in any state -> IDLE next cycle; digit=0, divider=0, tick=0.
- Period 00 = 1 cycle: divider is always 0, so tick is high every cycle in RUN and digit advances every cycle.
- Latency:
  - First tick after start from IDLE is exactly period cycles after the start cycle.
  - Subsequent ticks are exactly period cycles apart while in RUN.
- speed_sel changes mid-period never alter the current period.
- running = (state==RUN), registered.
- HEX0 decode, standard active-low, bit0=segment a … bit6=segment g:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Arithmetic: digit is 4-bit modular; divider is unsigned CNT_W bits and never underflows because reload occurs at 0.

Decomposition:
- Package hex_rate_pkg holds:
  - state enum (IDLE, RUN, PAUSE).
  - function period(sel, CLK_HZ) returning the CNT_W-bit cycle count.
  - 7-segment pattern constants.
- One sub-module, seg7_decode (digit -> HEX0, purely combinational).
- FSM, divider and digit register stay in hex_rate_sequencer.

Test Plan:
All scenarios use CLK_HZ=4.
- Reset held 3 cycles -> digit=0, tick=0, running=0, HEX0=1000000.
- speed_sel=01, up_down=1, start pulse -> ticks at cycles 4, 8, 12 after start; digit 1, 2, 3; running=1 throughout.
- speed_sel=00, run 17 cycles up -> digit wraps F->0 on the 16th tick; with up_down=0 from 0 -> next tick gives F (HEX0=0001110).
- speed_sel=10 running; switch to 11 two cycles into a period -> current tick still 8 cycles after the previous one; next tick 16 cycles later.
- stop asserted with divider=2 for 10 cycles, then start -> no tick while paused; tick exactly 3 cycles after resume; digit unchanged during pause.
- start, stop and clear asserted together in RUN with divider==0 -> no tick; next cycle state=IDLE, digit=0, running=0.

Source files
------------

// File: rtl/hex_rate_pkg.sv
// -----------------------------------------------------------------------------
// hex_rate_pkg
// Shared definitions for the hex rate sequencer:
//   - state_t   : sequencer FSM states (IDLE, RUN, PAUSE)
//   - period()  : cycles per tick for a 2-bit rate select at a given clock rate
//   - SEG_*     : active-low 7-segment patterns, bit0 = segment a .. bit6 = g
// -----------------------------------------------------------------------------
package hex_rate_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // 00 = every cycle, 01 = 1x, 10 = 2x, 11 = 4x the clock rate.
    function automatic logic [31:0] period(input logic [1:0] sel,
                                           input int unsigned clk_hz);
        logic [31:0] p;
        case (sel)
            2'b00:   p = 32'd1;
            2'b01:   p = clk_hz;
            2'b10:   p = clk_hz * 32'd2;
            default: p = clk_hz * 32'd4;
        endcase
        return p;
    endfunction

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Purely combinational hex digit to active-low 7-segment decoder.
// Ports:
//   i_digit  in  4  hex value to display
//   o_seg    out 7  active-low segments, bit0 = a .. bit6 = g
// -----------------------------------------------------------------------------
module seg7_decode
    import hex_rate_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_0;
        case (i_digit)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            default: o_seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/hex_rate_sequencer.sv
// -----------------------------------------------------------------------------
// hex_rate_sequencer
// Run/pause/clear controller for a rate divider and a 4-bit up/down hex digit
// driving one 7-segment display. Rate changes only take effect when the
// divider reloads at a tick, so a period in progress is never altered.
//
// Ports:
//   CLOCK_50   in  1  system clock
//   Reset      in  1  synchronous active-high reset
//   speed_sel  in  2  tick period select (00=1, 01=1x, 10=2x, 11=4x CLK_HZ)
//   start      in  1  run / resume (level)
//   stop       in  1  pause (level)
//   clear      in  1  back to idle, digit to 0 (level)
//   up_down    in  1  1 = count up, 0 = count down
//   digit      out 4  current hex value
//   tick       out 1  registered pulse on the cycle digit updates
//   running    out 1  registered, high in RUN
//   HEX0       out 7  active-low segments for digit
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | stopped, waiting for start; divider cleared
// RUN   | divider counting down, tick + digit update when it hits 0
// PAUSE | divider and digit frozen; start resumes without reload
// -----------------------------------------------------------------------------
module hex_rate_sequencer
    import hex_rate_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int          CNT_W  = 28
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic [1:0] speed_sel,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       up_down,
    output logic [3:0] digit,
    output logic       tick,
    output logic       running,
    output logic [6:0] HEX0
);

    localparam logic [CNT_W-1:0] ONE = 1;

    state_t           r_state;
    logic [CNT_W-1:0] r_divider;
    logic [1:0]       r_active_sel;
    logic [3:0]       r_digit;
    logic             r_tick;
    logic             r_running;

    logic [CNT_W-1:0] w_reload;
    logic             w_div_zero;

    // Reload always comes from the live select: a change made mid-period or
    // while paused is picked up at the next reload only.
    assign w_reload = CNT_W'(period(speed_sel, CLK_HZ) - 32'd1);

    // The single-cycle rate keeps the divider parked at 0, so every RUN cycle
    // is a terminal count.
    assign w_div_zero = (r_divider == '0) || (r_active_sel == 2'b00);

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_divider    <= '0;
            r_active_sel <= 2'b00;
            r_digit      <= 4'h0;
            r_tick       <= 1'b0;
            r_running    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (clear) begin
                r_state   <= IDLE;
                r_digit   <= 4'h0;
                r_divider <= '0;
                r_running <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!stop && start) begin
                            r_state      <= RUN;
                            r_running    <= 1'b1;
                            r_active_sel <= speed_sel;
                            r_divider    <= w_reload;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            r_state   <= PAUSE;
                            r_running <= 1'b0;
                        end else if (w_div_zero) begin
                            r_tick       <= 1'b1;
                            r_digit      <= up_down ? (r_digit + 4'd1)
                                                    : (r_digit - 4'd1);
                            r_active_sel <= speed_sel;
                            r_divider    <= w_reload;
                        end else begin
                            r_divider <= r_divider - ONE;
                        end
                    end
                    PAUSE: begin
                        if (!stop && start) begin
                            r_state   <= RUN;
                            r_running <= 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign digit   = r_digit;
    assign tick    = r_tick;
    assign running = r_running;

    seg7_decode u_seg7 (
        .i_digit (r_digit),
        .o_seg   (HEX0)
    );

endmodule

// File: tb/tb_hex_rate_sequencer.sv
module tb_hex_rate_sequencer;

    logic       CLOCK_50 = 1'b0;
    logic       Reset;
    logic [1:0] speed_sel;
    logic       start;
    logic       stop;
    logic       clear;
    logic       up_down;
    logic [3:0] digit;
    logic       tick;
    logic       running;
    logic [6:0] HEX0;

    int total = 0;
    int bad   = 0;

    logic [6:0] exp_seg [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    hex_rate_sequencer #(.CLK_HZ(4), .CNT_W(8)) dut (
        .CLOCK_50  (CLOCK_50),
        .Reset     (Reset),
        .speed_sel (speed_sel),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .up_down   (up_down),
        .digit     (digit),
        .tick      (tick),
        .running   (running),
        .HEX0      (HEX0)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; speed_sel = 2'b00; start = 1'b0; stop = 1'b0;
        clear = 1'b0; up_down = 1'b1;
        repeat (3) step();
        total++; if (digit !== 4'h0) begin bad++; $display("FAIL reset_digit got=%h exp=0", digit); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", tick); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b exp=0", running); end
        total++; if (HEX0 !== 7'b1000000) begin bad++; $display("FAIL reset_hex got=%b exp=1000000", HEX0); end
        Reset = 1'b0;
        step();
        total++; if (running !== 1'b0) begin bad++; $display("FAIL post_reset_running got=%b exp=0", running); end
    endtask

    // speed 01 at CLK_HZ=4: ticks 4, 8, 12 cycles after the start edge
    task automatic test_rate01();
        logic       e_tick;
        logic [3:0] e_dig;
        speed_sel = 2'b01; up_down = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        total++; if (running !== 1'b1) begin bad++; $display("FAIL r01_start_running got=%b exp=1", running); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL r01_start_tick got=%b exp=0", tick); end
        for (int c = 1; c <= 12; c++) begin
            step();
            e_tick = ((c % 4) == 0);
            e_dig  = 4'(c / 4);
            total++; if (tick !== e_tick) begin bad++; $display("FAIL r01_tick c=%0d got=%b exp=%b", c, tick, e_tick); end
            total++; if (digit !== e_dig) begin bad++; $display("FAIL r01_digit c=%0d got=%h exp=%h", c, digit, e_dig); end
            total++; if (running !== 1'b1) begin bad++; $display("FAIL r01_running c=%0d got=%b exp=1", c, running); end
        end
    endtask

    // continues from rate01: divider=3 after the tick, 2 one cycle later
    task automatic test_pause();
        step();
        stop = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            total++; if (tick !== 1'b0) begin bad++; $display("FAIL pause_tick i=%0d got=%b exp=0", i, tick); end
            total++; if (digit !== 4'h3) begin bad++; $display("FAIL pause_digit i=%0d got=%h exp=3", i, digit); end
            total++; if (running !== 1'b0) begin bad++; $display("FAIL pause_running i=%0d got=%b exp=0", i, running); end
        end
        stop = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        total++; if (running !== 1'b1) begin bad++; $display("FAIL resume_running got=%b exp=1", running); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL resume_tick0 got=%b exp=0", tick); end
        for (int k = 1; k <= 3; k++) begin
            step();
            total++; if (tick !== (k == 3)) begin bad++; $display("FAIL resume_tick k=%0d got=%b exp=%b", k, tick, (k == 3)); end
        end
        total++; if (digit !== 4'h4) begin bad++; $display("FAIL resume_digit got=%h exp=4", digit); end
    endtask

    // continues from pause: after 3 more cycles divider==0
    task automatic test_priority();
        repeat (3) step();
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL prio_pre_tick got=%b exp=0", tick); end
        start = 1'b1; stop = 1'b1; clear = 1'b1;
        step();
        start = 1'b0; stop = 1'b0; clear = 1'b0;
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL prio_tick got=%b exp=0", tick); end
        total++; if (digit !== 4'h0) begin bad++; $display("FAIL prio_digit got=%h exp=0", digit); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL prio_running got=%b exp=0", running); end
        total++; if (HEX0 !== 7'b1000000) begin bad++; $display("FAIL prio_hex got=%b exp=1000000", HEX0); end
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        total++; if (running !== 1'b0) begin bad++; $display("FAIL idle_stop_running got=%b exp=0", running); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL idle_stop_tick got=%b exp=0", tick); end
    endtask

    task automatic test_wrap();
        logic [3:0] e_dig;
        speed_sel = 2'b00; up_down = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL wrap_start_tick got=%b exp=0", tick); end
        for (int c = 1; c <= 16; c++) begin
            step();
            e_dig = 4'(c % 16);
            total++; if (tick !== 1'b1) begin bad++; $display("FAIL wrap_tick c=%0d got=%b exp=1", c, tick); end
            total++; if (digit !== e_dig) begin bad++; $display("FAIL wrap_digit c=%0d got=%h exp=%h", c, digit, e_dig); end
            total++; if (HEX0 !== exp_seg[e_dig]) begin bad++; $display("FAIL wrap_hex c=%0d got=%b exp=%b", c, HEX0, exp_seg[e_dig]); end
        end
        up_down = 1'b0;
        step();
        total++; if (digit !== 4'hF) begin bad++; $display("FAIL down_digit got=%h exp=F", digit); end
        total++; if (HEX0 !== 7'b0001110) begin bad++; $display("FAIL down_hex got=%b exp=0001110", HEX0); end
        total++; if (tick !== 1'b1) begin bad++; $display("FAIL down_tick got=%b exp=1", tick); end
        clear = 1'b1;
        step();
        clear = 1'b0;
        total++; if (digit !== 4'h0) begin bad++; $display("FAIL wrap_clear_digit got=%h exp=0", digit); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL wrap_clear_running got=%b exp=0", running); end
    endtask

    // speed 10 (8 cycles), switched to 11 (16 cycles) mid-period
    task automatic test_speed_change();
        logic       e_tick;
        logic [3:0] e_dig;
        speed_sel = 2'b10; up_down = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            if (c == 11) speed_sel = 2'b11;
            step();
            e_tick = (c == 8) || (c == 16) || (c == 32);
            e_dig  = (c < 8) ? 4'h0 : (c < 16) ? 4'h1 : (c < 32) ? 4'h2 : 4'h3;
            total++; if (tick !== e_tick) begin bad++; $display("FAIL spd_tick c=%0d got=%b exp=%b", c, tick, e_tick); end
            total++; if (digit !== e_dig) begin bad++; $display("FAIL spd_digit c=%0d got=%h exp=%h", c, digit, e_dig); end
        end
    endtask

    initial begin
        test_reset();
        test_rate01();
        test_pause();
        test_priority();
        test_wrap();
        test_speed_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
